seg_disp_sched: RTL and testbench

Time-multiplexes one hex 7-segment display between four requesters, each presenting a 16-bit value.
- Round-robin arbiter with a minimum dwell time per owner.
- Inserts a blanking gap between owners.
- Generates the digit-scan clock enable for the downstream hex display driver.
- Sits between the application blocks (ROM viewer, counters, debug taps) and the display driver; drives its x input and scan tick.

---
 rtl/seg_disp_sched_if.sv | 16 +
 rtl/seg_disp_sched.sv | 150 +++++++++++++++
 tb/tb_seg_disp_sched.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/seg_disp_sched_if.sv
// Requester/display-side bundle for seg_disp_sched: request/data inputs and
// grant, display value and scan-tick outputs.
interface seg_disp_sched_if;
  logic [3:0]  req;
  logic [63:0] data_in;
  logic [3:0]  gnt;
  logic [1:0]  owner;
  logic [15:0] disp_x;
  logic        blank;
  logic        scan_tick;

  modport master (output req, data_in,
                  input  gnt, owner, disp_x, blank, scan_tick);
  modport slave  (input  req, data_in,
                  output gnt, owner, disp_x, blank, scan_tick);
endinterface

// File: rtl/seg_disp_sched.sv
// Round-robin scheduler sharing one hex 7-seg display among four requesters,
// with dwell, blanking gap and scan-tick generation. SEG_SCHED_PRIO_EN gives requester 0 priority.
module seg_disp_sched #(
  parameter int PRESCALE    = 50000,
  parameter int DWELL       = 1000,
  parameter int BLANK_TICKS = 4
) (
  input  logic            cclk,
  input  logic            clr,
  seg_disp_sched_if.slave sif
);
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int DW = $clog2(DWELL + 1);
  localparam int BW = $clog2(BLANK_TICKS + 1);
  localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);
  localparam logic [DW-1:0] DWELL_C = DW'(DWELL);
  localparam logic [BW-1:0] BLANK_C = BW'(BLANK_TICKS);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_BLANK} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic          tick_q;
  logic [1:0]    ptr_q, ptr_d;
  logic [DW-1:0] dwell_q, dwell_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [3:0]    gnt_q, gnt_d;
  logic [1:0]    owner_q, owner_d;
  logic [15:0]   disp_q, disp_d;
  logic          blank_q, blank_d;

  logic [1:0] cand, rr_win, win;
  logic       prio_win, preempt, any_req, others, do_grant;

  // Free-running prescaler; the pulse lands the cycle after the terminal count.
  assign pre_d = (pre_q == PRE_MAX) ? '0 : pre_q + 1'b1;

  always_ff @(posedge cclk or posedge clr) begin
    if (clr) begin
      pre_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      tick_q <= (pre_q == PRE_MAX);
    end
  end

  // First asserted request after the pointer, wrapping; the last owner is considered last.
  always_comb begin
    cand   = '0;
    rr_win = ptr_q;
    for (int k = 4; k >= 1; k--) begin
      cand = ptr_q + 2'(k);
      if (sif.req[cand]) rr_win = cand;
    end
  end

  assign any_req = |sif.req;
  assign others  = |(sif.req & ~gnt_q);

`ifdef SEG_SCHED_PRIO_EN
  assign prio_win = sif.req[0];
  assign win      = sif.req[0] ? 2'd0 : rr_win;
  assign preempt  = sif.req[0] && (owner_q != 2'd0);
`else
  assign prio_win = 1'b0;
  assign win      = rr_win;
  assign preempt  = 1'b0;
`endif

  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    dwell_d  = dwell_q;
    bcnt_d   = bcnt_q;
    gnt_d    = gnt_q;
    owner_d  = owner_q;
    disp_d   = disp_q;
    blank_d  = blank_q;
    do_grant = 1'b0;
    case (state_q)
      S_IDLE: begin
        gnt_d   = '0;
        blank_d = 1'b1;
        if (any_req) do_grant = 1'b1;
      end
      S_GRANT: begin
        disp_d = sif.data_in[{owner_q, 4'h0} +: 16];
        if (tick_q && dwell_q != DWELL_C) dwell_d = dwell_q + 1'b1;
        if (!sif.req[owner_q] || (dwell_q == DWELL_C && others) || preempt) begin
          state_d = S_BLANK;
          gnt_d   = '0;
          blank_d = 1'b1;
          bcnt_d  = '0;
        end
      end
      S_BLANK: begin
        // Requests are only looked at once the gap has fully elapsed.
        if (bcnt_q == BLANK_C) begin
          if (any_req) do_grant = 1'b1;
          else         state_d  = S_IDLE;
        end else if (tick_q) begin
          bcnt_d = bcnt_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
        blank_d = 1'b1;
      end
    endcase
    if (do_grant) begin
      state_d = S_GRANT;
      gnt_d   = 4'b0001 << win;
      owner_d = win;
      dwell_d = '0;
      blank_d = 1'b0;
      if (!prio_win) ptr_d = win;
    end
  end

  // disp_x is cleared only by reset; idle and blank both hold the last shown value.
  always_ff @(posedge cclk or posedge clr) begin
    if (clr) begin
      state_q <= S_IDLE;
      ptr_q   <= 2'd3;
      dwell_q <= '0;
      bcnt_q  <= '0;
      gnt_q   <= '0;
      owner_q <= '0;
      disp_q  <= '0;
      blank_q <= 1'b1;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      dwell_q <= dwell_d;
      bcnt_q  <= bcnt_d;
      gnt_q   <= gnt_d;
      owner_q <= owner_d;
      disp_q  <= disp_d;
      blank_q <= blank_d;
    end
  end

  assign sif.gnt       = gnt_q;
  assign sif.owner     = owner_q;
  assign sif.disp_x    = disp_q;
  assign sif.blank     = blank_q;
  assign sif.scan_tick = tick_q;
endmodule

// File: tb/tb_seg_disp_sched.sv
// Directed bench for seg_disp_sched with PRESCALE=4, DWELL=3, BLANK_TICKS=2.
module tb_seg_disp_sched;
  logic cclk = 1'b0;
  logic clr  = 1'b1;
  int   total = 0;
  int   bad   = 0;

  seg_disp_sched_if sif();

  seg_disp_sched #(.PRESCALE(4), .DWELL(3), .BLANK_TICKS(2)) dut (
    .cclk (cclk),
    .clr  (clr),
    .sif  (sif)
  );

  always #5 cclk = ~cclk;

  task automatic tick();
    @(posedge cclk);
    #1;
  endtask

  task automatic do_reset();
    clr     = 1'b1;
    sif.req = 4'b0000;
    tick();
    tick();
    clr = 1'b0;
  endtask

  // Advance until grant presence equals want_gnt; counts ticks and blank errors on the way.
  task automatic run_until(input bit want_gnt, output int ticks, output int blank_err, output bit to);
    ticks = 0; blank_err = 0; to = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if ((sif.gnt != 4'b0000) == want_gnt) begin
        to = 1'b0;
        break;
      end
      if (sif.scan_tick) ticks++;
      if (sif.blank !== want_gnt) blank_err++;
      tick();
    end
  endtask

  task automatic test_reset();
    sif.req     = 4'b0000;
    sif.data_in = '0;
    clr = 1'b1;
    tick(); tick();
    clr = 1'b0;
    sif.req = 4'b0001;
    sif.data_in[15:0] = 16'h5555;
    tick(); tick(); tick();
    total++; if (sif.gnt !== 4'b0001) begin bad++; $display("FAIL pre_clr_gnt got=%b want=0001", sif.gnt); end
    clr = 1'b1;
    #2;
    total++; if (sif.gnt !== 4'b0000) begin bad++; $display("FAIL clr_gnt got=%b want=0000", sif.gnt); end
    total++; if (sif.blank !== 1'b1) begin bad++; $display("FAIL clr_blank got=%b want=1", sif.blank); end
    total++; if (sif.disp_x !== 16'h0000) begin bad++; $display("FAIL clr_disp got=%h want=0000", sif.disp_x); end
    total++; if (sif.owner !== 2'd0) begin bad++; $display("FAIL clr_owner got=%0d want=0", sif.owner); end
    total++; if (sif.scan_tick !== 1'b0) begin bad++; $display("FAIL clr_tick got=%b want=0", sif.scan_tick); end
    sif.req = 4'b0000;
    tick(); tick();
    clr = 1'b0;
    for (int n = 1; n <= 12; n++) begin
      tick();
      total++;
      if (sif.scan_tick !== (n % 4 == 0)) begin
        bad++; $display("FAIL prescale_n%0d got=%b want=%b", n, sif.scan_tick, (n % 4 == 0));
      end
    end
  endtask

  task automatic test_single();
    int ticks, miss;
    sif.data_in[15:0] = 16'h1234;
    sif.req = 4'b0001;
    tick();
    total++; if (sif.gnt !== 4'b0001) begin bad++; $display("FAIL single_gnt got=%b want=0001", sif.gnt); end
    total++; if (sif.owner !== 2'd0) begin bad++; $display("FAIL single_owner got=%0d want=0", sif.owner); end
    total++; if (sif.blank !== 1'b0) begin bad++; $display("FAIL single_blank got=%b want=0", sif.blank); end
    total++; if (sif.disp_x !== 16'h0000) begin bad++; $display("FAIL single_disp_lat got=%h want=0000", sif.disp_x); end
    tick();
    total++; if (sif.disp_x !== 16'h1234) begin bad++; $display("FAIL single_disp got=%h want=1234", sif.disp_x); end
    sif.data_in[15:0] = 16'hBEEF;
    #1;
    total++; if (sif.disp_x !== 16'h1234) begin bad++; $display("FAIL single_disp_hold got=%h want=1234", sif.disp_x); end
    tick();
    total++; if (sif.disp_x !== 16'hBEEF) begin bad++; $display("FAIL single_disp_chg got=%h want=beef", sif.disp_x); end
    ticks = 0; miss = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (sif.scan_tick) ticks++;
      if (sif.gnt !== 4'b0001) miss++;
    end
    total++; if (miss !== 0) begin bad++; $display("FAIL single_hold got=%0d lost cycles want=0", miss); end
    total++; if (ticks !== 5) begin bad++; $display("FAIL single_hold_ticks got=%0d want=5", ticks); end
  endtask

  task automatic test_empty();
    sif.req = 4'b0000;
    tick();
    total++; if (sif.gnt !== 4'b0000) begin bad++; $display("FAIL empty_gnt got=%b want=0000", sif.gnt); end
    total++; if (sif.blank !== 1'b1) begin bad++; $display("FAIL empty_blank got=%b want=1", sif.blank); end
    repeat (12) tick();
    total++; if (sif.gnt !== 4'b0000) begin bad++; $display("FAIL idle_gnt got=%b want=0000", sif.gnt); end
    total++; if (sif.blank !== 1'b1) begin bad++; $display("FAIL idle_blank got=%b want=1", sif.blank); end
    total++; if (sif.disp_x !== 16'hBEEF) begin bad++; $display("FAIL idle_disp got=%h want=beef", sif.disp_x); end
  endtask

  task automatic test_round_robin();
    int ticks, berr;
    bit to;
    logic [1:0]  exp_seq [5];
    logic [63:0] dv;
    dv = {16'hD333, 16'hC222, 16'hB111, 16'hA000};
    do_reset();
    sif.data_in = dv;
`ifdef SEG_SCHED_PRIO_EN
    exp_seq = '{2'd1, 2'd2, 2'd3, 2'd1, 2'd2};
    sif.req = 4'b1110;
`else
    exp_seq = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    sif.req = 4'b1111;
`endif
    for (int k = 0; k < 5; k++) begin
      run_until(1'b1, ticks, berr, to);
      total++; if (to) begin bad++; $display("FAIL rr%0d_wait timeout", k); end
      total++; if (berr !== 0) begin bad++; $display("FAIL rr%0d_gap_blank got=%0d errs want=0", k, berr); end
      if (k > 0) begin
        total++; if (ticks !== 2) begin bad++; $display("FAIL rr%0d_gap_ticks got=%0d want=2", k, ticks); end
      end
      total++; if (sif.gnt !== (4'b0001 << exp_seq[k])) begin bad++; $display("FAIL rr%0d_gnt got=%b want=%b", k, sif.gnt, 4'b0001 << exp_seq[k]); end
      total++; if (sif.owner !== exp_seq[k]) begin bad++; $display("FAIL rr%0d_owner got=%0d want=%0d", k, sif.owner, exp_seq[k]); end
      run_until(1'b0, ticks, berr, to);
      total++; if (to) begin bad++; $display("FAIL rr%0d_release timeout", k); end
      total++; if (ticks !== 3) begin bad++; $display("FAIL rr%0d_dwell got=%0d want=3", k, ticks); end
      total++; if (berr !== 0) begin bad++; $display("FAIL rr%0d_grant_blank got=%0d errs want=0", k, berr); end
      total++; if (sif.disp_x !== dv[{exp_seq[k], 4'h0} +: 16]) begin bad++; $display("FAIL rr%0d_disp got=%h want=%h", k, sif.disp_x, dv[{exp_seq[k], 4'h0} +: 16]); end
    end
  endtask

  task automatic test_early_release();
    int ticks, berr;
    bit to, seen;
    do_reset();
    sif.req = 4'b1100;
    run_until(1'b1, ticks, berr, to);
    total++; if (sif.gnt !== 4'b0100) begin bad++; $display("FAIL early_gnt2 got=%b want=0100", sif.gnt); end
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (sif.scan_tick) begin seen = 1'b1; break; end
      tick();
    end
    total++; if (!seen) begin bad++; $display("FAIL early_tick timeout"); end
    sif.req = 4'b1000;
    tick();
    total++; if (sif.gnt !== 4'b0000) begin bad++; $display("FAIL early_blank_gnt got=%b want=0000", sif.gnt); end
    total++; if (sif.blank !== 1'b1) begin bad++; $display("FAIL early_blank got=%b want=1", sif.blank); end
    run_until(1'b1, ticks, berr, to);
    total++; if (to) begin bad++; $display("FAIL early_wait timeout"); end
    total++; if (ticks !== 2) begin bad++; $display("FAIL early_gap_ticks got=%0d want=2", ticks); end
    total++; if (sif.gnt !== 4'b1000) begin bad++; $display("FAIL early_gnt3 got=%b want=1000", sif.gnt); end
    total++; if (sif.owner !== 2'd3) begin bad++; $display("FAIL early_owner got=%0d want=3", sif.owner); end
  endtask

  task automatic test_priority();
    int ticks, berr;
    bit to;
    do_reset();
    sif.req = 4'b0010;
    run_until(1'b1, ticks, berr, to);
    total++; if (sif.gnt !== 4'b0010) begin bad++; $display("FAIL prio_gnt1 got=%b want=0010", sif.gnt); end
    sif.req = 4'b0011;
`ifdef SEG_SCHED_PRIO_EN
    tick();
    total++; if (sif.gnt !== 4'b0000) begin bad++; $display("FAIL prio_preempt got=%b want=0000", sif.gnt); end
`else
    run_until(1'b0, ticks, berr, to);
    total++; if (ticks !== 3) begin bad++; $display("FAIL prio_keep_ticks got=%0d want=3", ticks); end
`endif
    run_until(1'b1, ticks, berr, to);
    total++; if (to) begin bad++; $display("FAIL prio_wait timeout"); end
    total++; if (sif.gnt !== 4'b0001) begin bad++; $display("FAIL prio_gnt0 got=%b want=0001", sif.gnt); end
  endtask

  initial begin
    sif.req     = 4'b0000;
    sif.data_in = '0;
    test_reset();
    test_single();
    test_empty();
    test_round_robin();
    test_early_release();
    test_priority();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
